cache_controller: RTL
=====================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, is the maximum number of cycles to wait for mem_ack before aborting.
REQ-002 Parameter CNT_W, default 16, is the width of the hit and miss statistics counters.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  8  write data.
- cpu_rdata  out  8  read data; valid while cpu_ready=1 and cpu_we=0.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  qualifies cpu_ready; 1 = memory timeout.
- cm_address_word  out  32  address to cache_memory.
- cm_try_read  out  1  cache lookup/read strobe.
- cm_try_write  out  1  cache write/fill strobe.
- cm_write_data  out  8  cache write data.
- cm_data  in  8  cache read data.
- cm_ages  in  8  4 ways x 2-bit age; way w = bits [2w+1:2w].
- cm_hit_miss  in  1  1 = hit; valid the cycle after a strobe.
- cm_hit_miss_set  in  4  set index of the last lookup.
- mem_req  out  1  backing-memory request; held until mem_ack or timeout.
- mem_we  out  1  backing-memory write enable.
- mem_addr  out  32  backing-memory address.
- mem_wdata  out  8  backing-memory write data.
- mem_rdata  in  8  backing-memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle acknowledge.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.
- victim_way  out  2  lowest-index way with age 2'b11, else 0; combinational from cm_ages.

Function
REQ-004 States: IDLE, LOOKUP, CHECK, MEM_RD, FILL, MEM_WR, CACHE_WR, DONE.
REQ-005 IDLE: when cpu_req=1, capture cpu_addr, cpu_we and cpu_wdata into internal registers and go to LOOKUP; inputs are not resampled until the next IDLE.
REQ-006 LOOKUP: assert cm_try_read=1 with cm_address_word = captured address for exactly one cycle, then go to CHECK.
REQ-007 CHECK, read with cm_hit_miss=1: latch cm_data into cpu_rdata, increment hit_count, go to DONE (read-hit latency is 4 cycles from cpu_req to cpu_ready).
REQ-008 CHECK, read with cm_hit_miss=0: increment miss_count and go to MEM_RD.
REQ-009 CHECK, write (hit or miss): increment the matching counter and go to MEM_WR; the write policy is write-through.
REQ-010 MEM_RD: assert mem_req=1 and mem_we=0; on mem_ack, latch mem_rdata into cpu_rdata and the fill register, then go to FILL.
REQ-011 FILL: assert cm_try_write=1 for one cycle with cm_write_data = fill register; cache_memory selects the victim by age; then go to DONE.
REQ-012 MEM_WR: assert mem_req=1, mem_we=1, mem_wdata = captured write data; on mem_ack go to CACHE_WR if the lookup hit, else DONE (no write-allocate).
REQ-013 CACHE_WR: assert cm_try_write=1 for one cycle with the captured write data, then go to DONE.
REQ-014 DONE: pulse cpu_ready=1 for one cycle, then go to IDLE; a new request is accepted no earlier than the following cycle.
REQ-015 Timeout: a cycle counter runs in MEM_RD and MEM_WR. When it reaches MEM_TIMEOUT without mem_ack, drop mem_req, skip the cache write, and go to DONE with cpu_err=1 and cpu_rdata=8'h00.
REQ-016 mem_ack outside MEM_RD/MEM_WR is ignored; cm_try_read and cm_try_write are never asserted together.
REQ-017 hit_count and miss_count saturate at all-ones and never wrap.
REQ-018 mem_addr and cm_address_word hold the captured address whenever the respective strobe or mem_req is high; otherwise they hold their last value.

Reset
REQ-019 rst_b=0 asynchronously forces: state IDLE; all strobes, cpu_ready, cpu_err and mem_req = 0; cpu_rdata, both counters, the captured registers and the timeout counter = 0.
REQ-020 Reset asserted mid-transaction abandons the transaction with no cpu_ready and no cache write; after release the FSM waits in IDLE.

Verification
REQ-021 Read hit: cpu_req, read, addr 0x0000_0040, cm_hit_miss=1, cm_data=8'hA5 -> cpu_ready 4 cycles later, cpu_rdata=8'hA5, hit_count=1, no mem_req.
REQ-022 Read miss: cm_hit_miss=0, mem_ack 3 cycles after mem_req with mem_rdata=8'h3C -> one cm_try_write with 8'h3C, cpu_rdata=8'h3C, miss_count=1.
REQ-023 Write hit, data 8'h77 -> mem write of 8'h77, then one cm_try_write of 8'h77, then cpu_ready; write miss -> mem write only, no cm_try_write.
REQ-024 Timeout with MEM_TIMEOUT=4 and mem_ack never asserted -> mem_req high for 4 cycles, then cpu_ready=1 with cpu_err=1 and no cache write.
REQ-025 rst_b pulsed low during MEM_RD -> outputs zero immediately, no cpu_ready; a new request after release completes normally.
REQ-026 Counter saturation with CNT_W=2 and 5 hits -> hit_count=2'b11.

Source files
------------

// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//
// Purpose:
//    Sequences single-byte CPU accesses against an external set-associative
//    cache (cache_memory) and a slow backing memory. Reads that hit return
//    cache data; read misses fetch from memory and fill the cache. Writes are
//    write-through with no write-allocate: memory is always written, and the
//    cache is updated only when the lookup hit. Memory accesses are aborted
//    after MEM_TIMEOUT cycles without an acknowledge.
//
// Ports:
//    clk, rst_b          clock, asynchronous active-low reset
//    cpu_*               CPU request/response handshake (cpu_ready is a pulse)
//    cm_*                cache_memory lookup/write strobes, address, data,
//                        hit flag and per-way ages
//    mem_*               backing-memory request/acknowledge interface
//    hit_count,
//    miss_count          saturating access statistics
//    victim_way          lowest-index way whose age is 2'b11, else way 0
// -----------------------------------------------------------------------------
module cache_controller #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_b,
   // CPU side
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [31:0]      cpu_addr,
   input  logic [7:0]       cpu_wdata,
   output logic [7:0]       cpu_rdata,
   output logic             cpu_ready,
   output logic             cpu_err,
   // cache_memory side
   output logic [31:0]      cm_address_word,
   output logic             cm_try_read,
   output logic             cm_try_write,
   output logic [7:0]       cm_write_data,
   input  logic [7:0]       cm_data,
   input  logic [7:0]       cm_ages,
   input  logic             cm_hit_miss,
   input  logic [3:0]       cm_hit_miss_set,
   // backing memory side
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [7:0]       mem_wdata,
   input  logic [7:0]       mem_rdata,
   input  logic             mem_ack,
   // statistics / replacement hint
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   output logic [1:0]       victim_way
);

   // The wait counter only ever needs to reach MEM_TIMEOUT-1: the timeout
   // fires on the last permitted cycle of mem_req, so mem_req stays high for
   // exactly MEM_TIMEOUT cycles.
   localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, LOOKUP, CHECK, MEM_RD, FILL, MEM_WR, CACHE_WR, DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [31:0]       addr_reg, addr_next;
   logic              we_reg, we_next;
   logic [7:0]        wdata_reg, wdata_next;
   logic              hit_reg, hit_next;
   logic [7:0]        fill_reg, fill_next;
   logic [7:0]        rdata_reg, rdata_next;
   logic              err_reg, err_next;
   logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
   logic [CNT_W-1:0]  hit_count_reg, hit_count_next;
   logic [CNT_W-1:0]  miss_count_reg, miss_count_next;
   logic [31:0]       cm_addr_hold_reg, cm_addr_hold_next;
   logic [31:0]       mem_addr_hold_reg, mem_addr_hold_next;

   // The set index reported by cache_memory is informational only here.
   logic unused_inputs;
   assign unused_inputs = ^cm_hit_miss_set;

   // ---------------------------------------------------------------------
   // Victim selection: one "oldest" flag per way, lowest index wins.
   // ---------------------------------------------------------------------
   logic [3:0] way_oldest;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_way_age
         assign way_oldest[gi] = &cm_ages[2*gi +: 2];
      end
   endgenerate

   always_comb begin
      victim_way = 2'd0;
      if (way_oldest[0])      victim_way = 2'd0;
      else if (way_oldest[1]) victim_way = 2'd1;
      else if (way_oldest[2]) victim_way = 2'd2;
      else if (way_oldest[3]) victim_way = 2'd3;
   end

   // ---------------------------------------------------------------------
   // Next-state, datapath and strobe logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      addr_next       = addr_reg;
      we_next         = we_reg;
      wdata_next      = wdata_reg;
      hit_next        = hit_reg;
      fill_next       = fill_reg;
      rdata_next      = rdata_reg;
      err_next        = err_reg;
      to_cnt_next     = '0;
      hit_count_next  = hit_count_reg;
      miss_count_next = miss_count_reg;

      cpu_ready       = 1'b0;
      cpu_err         = 1'b0;
      cm_try_read     = 1'b0;
      cm_try_write    = 1'b0;
      cm_write_data   = 8'h00;
      mem_req         = 1'b0;
      mem_we          = 1'b0;

      case (state_reg)
         IDLE: begin
            if (cpu_req) begin
               addr_next  = cpu_addr;
               we_next    = cpu_we;
               wdata_next = cpu_wdata;
               err_next   = 1'b0;
               state_next = LOOKUP;
            end
         end

         LOOKUP: begin
            cm_try_read = 1'b1;
            state_next  = CHECK;
         end

         CHECK: begin
            hit_next = cm_hit_miss;
            if (cm_hit_miss) begin
               if (hit_count_reg != '1) hit_count_next = hit_count_reg + 1'b1;
            end else begin
               if (miss_count_reg != '1) miss_count_next = miss_count_reg + 1'b1;
            end
            if (we_reg) begin
               state_next = MEM_WR;
            end else if (cm_hit_miss) begin
               rdata_next = cm_data;
               state_next = DONE;
            end else begin
               state_next = MEM_RD;
            end
         end

         MEM_RD: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               rdata_next = mem_rdata;
               fill_next  = mem_rdata;
               state_next = FILL;
            end else if (to_cnt_reg == TO_LAST) begin
               err_next   = 1'b1;
               rdata_next = 8'h00;
               state_next = DONE;
            end else begin
               to_cnt_next = to_cnt_reg + 1'b1;
            end
         end

         FILL: begin
            // cache_memory picks the victim way from its own ages.
            cm_try_write  = 1'b1;
            cm_write_data = fill_reg;
            state_next    = DONE;
         end

         MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ack) begin
               // No write-allocate: only a line that already hit is updated.
               state_next = hit_reg ? CACHE_WR : DONE;
            end else if (to_cnt_reg == TO_LAST) begin
               err_next   = 1'b1;
               rdata_next = 8'h00;
               state_next = DONE;
            end else begin
               to_cnt_next = to_cnt_reg + 1'b1;
            end
         end

         CACHE_WR: begin
            cm_try_write  = 1'b1;
            cm_write_data = wdata_reg;
            state_next    = DONE;
         end

         DONE: begin
            cpu_ready  = 1'b1;
            cpu_err    = err_reg;
            state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase

      // Addresses only follow the captured address while their strobe is up
      // and otherwise keep whatever they last showed.
      cm_address_word    = (cm_try_read || cm_try_write) ? addr_reg : cm_addr_hold_reg;
      mem_addr           = mem_req ? addr_reg : mem_addr_hold_reg;
      cm_addr_hold_next  = cm_address_word;
      mem_addr_hold_next = mem_addr;
   end

   assign cpu_rdata  = rdata_reg;
   assign mem_wdata  = wdata_reg;
   assign hit_count  = hit_count_reg;
   assign miss_count = miss_count_reg;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_reg         <= IDLE;
         addr_reg          <= '0;
         we_reg            <= 1'b0;
         wdata_reg         <= '0;
         hit_reg           <= 1'b0;
         fill_reg          <= '0;
         rdata_reg         <= '0;
         err_reg           <= 1'b0;
         to_cnt_reg        <= '0;
         hit_count_reg     <= '0;
         miss_count_reg    <= '0;
         cm_addr_hold_reg  <= '0;
         mem_addr_hold_reg <= '0;
      end else begin
         state_reg         <= state_next;
         addr_reg          <= addr_next;
         we_reg            <= we_next;
         wdata_reg         <= wdata_next;
         hit_reg           <= hit_next;
         fill_reg          <= fill_next;
         rdata_reg         <= rdata_next;
         err_reg           <= err_next;
         to_cnt_reg        <= to_cnt_next;
         hit_count_reg     <= hit_count_next;
         miss_count_reg    <= miss_count_next;
         cm_addr_hold_reg  <= cm_addr_hold_next;
         mem_addr_hold_reg <= mem_addr_hold_next;
      end
   end

endmodule
